// File: rtl/calendar_counter_pkg.sv
// Shared definitions for the calendar counter: field widths, range limits,
// month lengths, the packed date/time record and a load range checker.
package calendar_counter_pkg;

    localparam int unsigned HOURS_W = 5;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned SEC_W   = 6;
    localparam int unsigned YEAR_W  = 7;
    localparam int unsigned MONTH_W = 4;
    localparam int unsigned DAY_W   = 5;

    localparam int unsigned HOURS_MAX = 23;
    localparam int unsigned MIN_MAX   = 59;
    localparam int unsigned SEC_MAX   = 59;
    localparam int unsigned YEAR_MAX  = 99;
    localparam int unsigned MONTH_MAX = 12;

    localparam int unsigned DAYS_28 = 28;
    localparam int unsigned DAYS_29 = 29;
    localparam int unsigned DAYS_30 = 30;
    localparam int unsigned DAYS_31 = 31;

    // Complete clock/calendar state, one record so load and hold are single assignments.
    typedef struct packed {
        logic [HOURS_W-1:0] hours;
        logic [MIN_W-1:0]   minutes;
        logic [SEC_W-1:0]   seconds;
        logic [YEAR_W-1:0]  year;
        logic [MONTH_W-1:0] month;
        logic [DAY_W-1:0]   day;
    } cal_fields_t;

    // True when every field lies in its legal range; dim is the month length
    // computed for the candidate month/year.
    function automatic logic fields_valid(cal_fields_t f, logic [DAY_W-1:0] dim);
        logic ok;
        ok = (f.hours   <= HOURS_W'(HOURS_MAX)) &&
             (f.minutes <= MIN_W'(MIN_MAX))     &&
             (f.seconds <= SEC_W'(SEC_MAX))     &&
             (f.year    <= YEAR_W'(YEAR_MAX))   &&
             (f.month   >= MONTH_W'(1))         &&
             (f.month   <= MONTH_W'(MONTH_MAX)) &&
             (f.day     >= DAY_W'(1))           &&
             (f.day     <= dim);
        return ok;
    endfunction

endpackage

// File: rtl/calendar_counter_if.sv
// Bus between the calendar counter and its user.
//   master: drives run/load/ld_*, observes time/date, load_ack/err, day_tick, leap
//   slave : the counter itself
interface calendar_counter_if
    import calendar_counter_pkg::*;
();
    logic               run;
    logic               load;
    logic [HOURS_W-1:0] ld_hours;
    logic [MIN_W-1:0]   ld_minutes;
    logic [SEC_W-1:0]   ld_seconds;
    logic [YEAR_W-1:0]  ld_year;
    logic [MONTH_W-1:0] ld_month;
    logic [DAY_W-1:0]   ld_day;

    logic [HOURS_W-1:0] hours;
    logic [MIN_W-1:0]   minutes;
    logic [SEC_W-1:0]   seconds;
    logic [YEAR_W-1:0]  year;
    logic [MONTH_W-1:0] month;
    logic [DAY_W-1:0]   day;
    logic               load_ack;
    logic               load_err;
    logic               day_tick;
    logic               leap;

    modport master (
        output run, load, ld_hours, ld_minutes, ld_seconds, ld_year, ld_month, ld_day,
        input  hours, minutes, seconds, year, month, day,
        input  load_ack, load_err, day_tick, leap
    );

    modport slave (
        input  run, load, ld_hours, ld_minutes, ld_seconds, ld_year, ld_month, ld_day,
        output hours, minutes, seconds, year, month, day,
        output load_ack, load_err, day_tick, leap
    );
endinterface

// File: rtl/calendar_counter_month_days.sv
// Combinational month length lookup.
//   month, year : date being evaluated (year 0-99 = 2000-2099)
//   days        : number of days in that month
//   leap        : year is a leap year (every 4th year, 2000 included)
module month_days
    import calendar_counter_pkg::*;
(
    input  logic [MONTH_W-1:0] month,
    input  logic [YEAR_W-1:0]  year,
    output logic [DAY_W-1:0]   days,
    output logic               leap
);

    // Within 2000-2099 the century rules never apply, so divisibility by 4 suffices.
    always_comb begin
        leap = (year[1:0] == 2'd0);
        days = DAY_W'(DAYS_31);
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: days = DAY_W'(DAYS_30);
            4'd2:                    days = leap ? DAY_W'(DAYS_29) : DAY_W'(DAYS_28);
            default:                 days = DAY_W'(DAYS_31);
        endcase
    end

endmodule

// File: rtl/calendar_counter.sv
// Real-time clock/calendar counting one second per clk_1Hz edge.
//   clk_1Hz : one rising edge per second
//   rst     : asynchronous active-high reset to 00:00:00 RST_YEAR-RST_MONTH-RST_DAY
//   bus     : run/load controls and ld_* values in; time, date, load_ack,
//             load_err, day_tick (registered pulses) and leap (combinational) out
module calendar_counter
    import calendar_counter_pkg::*;
#(
    parameter int unsigned RST_YEAR  = 24,
    parameter int unsigned RST_MONTH = 1,
    parameter int unsigned RST_DAY   = 1
) (
    input  logic                  clk_1Hz,
    input  logic                  rst,
    calendar_counter_if.slave     bus
);

    localparam cal_fields_t RST_FIELDS = '{
        hours:   '0,
        minutes: '0,
        seconds: '0,
        year:    YEAR_W'(RST_YEAR),
        month:   MONTH_W'(RST_MONTH),
        day:     DAY_W'(RST_DAY)
    };

    cal_fields_t        cur_q, cur_d;
    cal_fields_t        ld_f;
    logic               load_ack_q, load_ack_d;
    logic               load_err_q, load_err_d;
    logic               day_tick_q, day_tick_d;

    logic [DAY_W-1:0]   cur_days;
    logic               cur_leap;
    logic [DAY_W-1:0]   ld_days;
    logic               ld_leap_unused;
    logic               ld_valid;

    logic               sec_wrap, min_wrap, hr_wrap, day_wrap, mon_wrap, yr_wrap;

    // Month length of the running date (drives rollover) and of the load candidate.
    month_days u_cur_days (
        .month (cur_q.month),
        .year  (cur_q.year),
        .days  (cur_days),
        .leap  (cur_leap)
    );

    month_days u_ld_days (
        .month (bus.ld_month),
        .year  (bus.ld_year),
        .days  (ld_days),
        .leap  (ld_leap_unused)
    );

    // Load candidate record and its validity.
    always_comb begin
        ld_f = '{
            hours:   bus.ld_hours,
            minutes: bus.ld_minutes,
            seconds: bus.ld_seconds,
            year:    bus.ld_year,
            month:   bus.ld_month,
            day:     bus.ld_day
        };
        ld_valid = fields_valid(ld_f, ld_days);
    end

    // Carry chain: each wrap only matters when all lower fields wrap too.
    always_comb begin
        sec_wrap = (cur_q.seconds >= SEC_W'(SEC_MAX));
        min_wrap = sec_wrap && (cur_q.minutes >= MIN_W'(MIN_MAX));
        hr_wrap  = min_wrap && (cur_q.hours >= HOURS_W'(HOURS_MAX));
        day_wrap = hr_wrap  && (cur_q.day >= cur_days);
        mon_wrap = day_wrap && (cur_q.month >= MONTH_W'(MONTH_MAX));
        yr_wrap  = mon_wrap && (cur_q.year >= YEAR_W'(YEAR_MAX));
    end

    // Next state: load wins over run; a rejected load still suppresses the increment.
    always_comb begin
        cur_d      = cur_q;
        load_ack_d = 1'b0;
        load_err_d = 1'b0;
        day_tick_d = 1'b0;

        if (bus.load) begin
            if (ld_valid) begin
                cur_d      = ld_f;
                load_ack_d = 1'b1;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.run) begin
            cur_d.seconds = sec_wrap ? '0 : cur_q.seconds + SEC_W'(1);
            if (sec_wrap) begin
                cur_d.minutes = min_wrap ? '0 : cur_q.minutes + MIN_W'(1);
            end
            if (min_wrap) begin
                cur_d.hours = hr_wrap ? '0 : cur_q.hours + HOURS_W'(1);
            end
            if (hr_wrap) begin
                cur_d.day  = day_wrap ? DAY_W'(1) : cur_q.day + DAY_W'(1);
                day_tick_d = 1'b1;
            end
            if (day_wrap) begin
                cur_d.month = mon_wrap ? MONTH_W'(1) : cur_q.month + MONTH_W'(1);
            end
            if (mon_wrap) begin
                cur_d.year = yr_wrap ? '0 : cur_q.year + YEAR_W'(1);
            end
        end
    end

    // State and pulse registers.
    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            cur_q      <= RST_FIELDS;
            load_ack_q <= 1'b0;
            load_err_q <= 1'b0;
            day_tick_q <= 1'b0;
        end else begin
            cur_q      <= cur_d;
            load_ack_q <= load_ack_d;
            load_err_q <= load_err_d;
            day_tick_q <= day_tick_d;
        end
    end

    assign bus.hours    = cur_q.hours;
    assign bus.minutes  = cur_q.minutes;
    assign bus.seconds  = cur_q.seconds;
    assign bus.year     = cur_q.year;
    assign bus.month    = cur_q.month;
    assign bus.day      = cur_q.day;
    assign bus.load_ack = load_ack_q;
    assign bus.load_err = load_err_q;
    assign bus.day_tick = day_tick_q;
    assign bus.leap     = cur_leap;

endmodule
